// File: rtl/hazard_ctrl_unit_if.sv
// rtl/hazard_ctrl_unit_if.sv - pipeline <-> hazard unit signal bundle
//
// Purpose: groups the pipeline-stage status inputs and the stage-control
// outputs of hazard_ctrl_unit into one interface.
// Ports (signals):
//   IF_ID_rs1/rs2, IF_ID_uses_rs2, IF_ID_mem_write : ID instruction sources
//   ID_EX_rd, ID_EX_mem_read                         : EX instruction (load)
//   EX_MEM_mem_access, EX_branch_taken               : MEM access, EX redirect
//   pc_write, IF_ID_write, ID_EX_write, EX_MEM_write : stage write enables
//   IF_ID_flush, control_mux_sel, MEM_WB_bubble      : flush / bubble controls
//   hazard_state, stall_cycles                       : status
// Modports: master = pipeline side, slave = hazard unit side.
interface hazard_ctrl_unit_if #(
   parameter int REG_W = 5,
   parameter int CNT_W = 16
);
   logic [REG_W-1:0] IF_ID_rs1;
   logic [REG_W-1:0] IF_ID_rs2;
   logic             IF_ID_uses_rs2;
   logic             IF_ID_mem_write;
   logic [REG_W-1:0] ID_EX_rd;
   logic             ID_EX_mem_read;
   logic             EX_MEM_mem_access;
   logic             EX_branch_taken;

   logic             pc_write;
   logic             IF_ID_write;
   logic             ID_EX_write;
   logic             EX_MEM_write;
   logic             IF_ID_flush;
   logic             control_mux_sel;
   logic             MEM_WB_bubble;
   logic [1:0]       hazard_state;
   logic [CNT_W-1:0] stall_cycles;

   modport master (
      output IF_ID_rs1, IF_ID_rs2, IF_ID_uses_rs2, IF_ID_mem_write,
             ID_EX_rd, ID_EX_mem_read, EX_MEM_mem_access, EX_branch_taken,
      input  pc_write, IF_ID_write, ID_EX_write, EX_MEM_write,
             IF_ID_flush, control_mux_sel, MEM_WB_bubble,
             hazard_state, stall_cycles
   );

   modport slave (
      input  IF_ID_rs1, IF_ID_rs2, IF_ID_uses_rs2, IF_ID_mem_write,
             ID_EX_rd, ID_EX_mem_read, EX_MEM_mem_access, EX_branch_taken,
      output pc_write, IF_ID_write, ID_EX_write, EX_MEM_write,
             IF_ID_flush, control_mux_sel, MEM_WB_bubble,
             hazard_state, stall_cycles
   );
endinterface

// File: rtl/hazard_ctrl_unit.sv
// rtl/hazard_ctrl_unit.sv - pipeline hazard control: mem freeze, branch flush, load-use stall
//
// Purpose: freezes the pipeline MEM_LAT-1 cycles per data-memory access,
// flushes IF/ID on a taken branch, stalls one cycle on a load-use hazard,
// and counts cycles in which the PC was held.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset (deassertion synchronised outside)
//   bus   : hazard_ctrl_unit_if.slave, pipeline status in / stage controls out
module hazard_ctrl_unit #(
   parameter int REG_W       = 5,
   parameter int MEM_LAT     = 1,
   parameter bit LDSD_BYPASS = 1'b1,
   parameter int CNT_W       = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   hazard_ctrl_unit_if.slave   bus
);

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_RELEASE  = 2'd2
   } state_t;

   localparam int WC_W = 5;
   // Wait-count preload; only meaningful when MEM_LAT >= 2.
   localparam logic [WC_W-1:0] LAT_M2 = (MEM_LAT >= 2) ? WC_W'(MEM_LAT - 2) : '0;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [WC_W-1:0]   r_wait_cnt;
   logic [WC_W-1:0]   w_wait_nxt;
   logic [CNT_W-1:0]  r_stall_cnt;

   logic w_frozen;
   logic w_load_use;
   logic w_ldsd_exempt;
   logic w_stall;

   logic w_pc_write;
   logic w_if_id_write;
   logic w_id_ex_write;
   logic w_ex_mem_write;
   logic w_if_id_flush;
   logic w_ctrl_mux_sel;
   logic w_mem_wb_bubble;

   // Load-use hazard against either source register; x0 never creates one.
   assign w_load_use = bus.ID_EX_mem_read && (bus.ID_EX_rd != '0) &&
                       ((bus.ID_EX_rd == bus.IF_ID_rs1) ||
                        (bus.IF_ID_uses_rs2 && (bus.ID_EX_rd == bus.IF_ID_rs2)));

   // A store that only needs the loaded value as store data gets it forwarded
   // in MEM, so no bubble is needed.
   assign w_ldsd_exempt = LDSD_BYPASS && bus.IF_ID_mem_write &&
                          (bus.ID_EX_rd == bus.IF_ID_rs2) &&
                          (bus.ID_EX_rd != bus.IF_ID_rs1);

   assign w_stall = w_load_use && !w_ldsd_exempt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_RUN;
         r_wait_cnt <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_wait_cnt <= w_wait_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_wait_nxt      = r_wait_cnt;
      w_frozen        = 1'b0;

      w_pc_write      = 1'b1;
      w_if_id_write   = 1'b1;
      w_id_ex_write   = 1'b1;
      w_ex_mem_write  = 1'b1;
      w_if_id_flush   = 1'b0;
      w_ctrl_mux_sel  = 1'b0;
      w_mem_wb_bubble = 1'b0;

      case (r_state)
         ST_RUN: begin
            // The access cycle itself is the first frozen cycle.
            if ((MEM_LAT > 1) && bus.EX_MEM_mem_access) begin
               w_frozen    = 1'b1;
               w_wait_nxt  = LAT_M2;
               w_state_nxt = (MEM_LAT == 2) ? ST_RELEASE : ST_MEM_WAIT;
            end
         end
         ST_MEM_WAIT: begin
            w_frozen   = 1'b1;
            w_wait_nxt = r_wait_cnt - 1'b1;
            if (r_wait_cnt == 1) begin
               w_state_nxt = ST_RELEASE;
            end
         end
         ST_RELEASE: begin
            // Access ignored here: the stalled access completes this cycle.
            w_state_nxt = ST_RUN;
         end
         default: begin
            w_state_nxt = ST_RUN;
         end
      endcase

      // Outputs held at no-hazard values throughout reset.
      if (rst_n) begin
         if (w_frozen) begin
            w_pc_write      = 1'b0;
            w_if_id_write   = 1'b0;
            w_id_ex_write   = 1'b0;
            w_ex_mem_write  = 1'b0;
            w_mem_wb_bubble = 1'b1;
         end else if (bus.EX_branch_taken) begin
            w_if_id_flush   = 1'b1;
            w_ctrl_mux_sel  = 1'b1;
         end else if (w_stall) begin
            w_pc_write      = 1'b0;
            w_if_id_write   = 1'b0;
            w_ctrl_mux_sel  = 1'b1;
         end
      end
   end

   // Saturating count of cycles in which the PC did not advance.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stall_cnt <= '0;
      end else if (!w_pc_write && (r_stall_cnt != '1)) begin
         r_stall_cnt <= r_stall_cnt + 1'b1;
      end
   end

   assign bus.pc_write        = w_pc_write;
   assign bus.IF_ID_write     = w_if_id_write;
   assign bus.ID_EX_write     = w_id_ex_write;
   assign bus.EX_MEM_write    = w_ex_mem_write;
   assign bus.IF_ID_flush     = w_if_id_flush;
   assign bus.control_mux_sel = w_ctrl_mux_sel;
   assign bus.MEM_WB_bubble   = w_mem_wb_bubble;
   assign bus.hazard_state    = r_state;
   assign bus.stall_cycles    = r_stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// tb/tb_hazard_ctrl_unit.sv - self-checking bench for hazard_ctrl_unit
module tb_hazard_ctrl_unit;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [4:0] s_rs1, s_rs2, s_rd;
   logic       s_uses2, s_mw, s_mr, s_acc, s_br;

   int checks = 0;
   int failures = 0;

   // Three configurations: A (LAT=1, bypass), C (LAT=4, bypass), D (LAT=8, no bypass)
   hazard_ctrl_unit_if #(.REG_W(5), .CNT_W(16)) if_a (), if_c (), if_d ();

   hazard_ctrl_unit #(.REG_W(5), .MEM_LAT(1), .LDSD_BYPASS(1'b1), .CNT_W(16))
      dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
   hazard_ctrl_unit #(.REG_W(5), .MEM_LAT(4), .LDSD_BYPASS(1'b1), .CNT_W(16))
      dut_c (.clk(clk), .rst_n(rst_n), .bus(if_c));
   hazard_ctrl_unit #(.REG_W(5), .MEM_LAT(8), .LDSD_BYPASS(1'b0), .CNT_W(16))
      dut_d (.clk(clk), .rst_n(rst_n), .bus(if_d));

   always_comb begin
      if_a.IF_ID_rs1 = s_rs1;  if_a.IF_ID_rs2 = s_rs2;  if_a.IF_ID_uses_rs2 = s_uses2;
      if_a.IF_ID_mem_write = s_mw;  if_a.ID_EX_rd = s_rd;  if_a.ID_EX_mem_read = s_mr;
      if_a.EX_MEM_mem_access = s_acc;  if_a.EX_branch_taken = s_br;
      if_c.IF_ID_rs1 = s_rs1;  if_c.IF_ID_rs2 = s_rs2;  if_c.IF_ID_uses_rs2 = s_uses2;
      if_c.IF_ID_mem_write = s_mw;  if_c.ID_EX_rd = s_rd;  if_c.ID_EX_mem_read = s_mr;
      if_c.EX_MEM_mem_access = s_acc;  if_c.EX_branch_taken = s_br;
      if_d.IF_ID_rs1 = s_rs1;  if_d.IF_ID_rs2 = s_rs2;  if_d.IF_ID_uses_rs2 = s_uses2;
      if_d.IF_ID_mem_write = s_mw;  if_d.ID_EX_rd = s_rd;  if_d.ID_EX_mem_read = s_mr;
      if_d.EX_MEM_mem_access = s_acc;  if_d.EX_branch_taken = s_br;
   end

   // Output vector order: {pc, if_id, id_ex, ex_mem, flush, mux_sel, bubble}
   logic [6:0]  o_vec [3];
   logic [1:0]  o_st  [3];
   logic [15:0] o_cnt [3];

   always_comb begin
      o_vec[0] = {if_a.pc_write, if_a.IF_ID_write, if_a.ID_EX_write, if_a.EX_MEM_write,
                  if_a.IF_ID_flush, if_a.control_mux_sel, if_a.MEM_WB_bubble};
      o_vec[1] = {if_c.pc_write, if_c.IF_ID_write, if_c.ID_EX_write, if_c.EX_MEM_write,
                  if_c.IF_ID_flush, if_c.control_mux_sel, if_c.MEM_WB_bubble};
      o_vec[2] = {if_d.pc_write, if_d.IF_ID_write, if_d.ID_EX_write, if_d.EX_MEM_write,
                  if_d.IF_ID_flush, if_d.control_mux_sel, if_d.MEM_WB_bubble};
      o_st[0] = if_a.hazard_state;  o_st[1] = if_c.hazard_state;  o_st[2] = if_d.hazard_state;
      o_cnt[0] = if_a.stall_cycles; o_cnt[1] = if_c.stall_cycles; o_cnt[2] = if_d.stall_cycles;
   end

   localparam logic [6:0] V_IDLE   = 7'b1111000;
   localparam logic [6:0] V_STALL  = 7'b0011010;
   localparam logic [6:0] V_FLUSH  = 7'b1111110;
   localparam logic [6:0] V_FROZEN = 7'b0000001;

   // Reference model: each access occupies a window of MEM_LAT cycles,
   // positions 0..MEM_LAT-2 frozen, position MEM_LAT-1 the release cycle.
   int lat [3] = '{1, 4, 8};
   bit byp [3] = '{1'b1, 1'b1, 1'b0};
   int ph  [3];
   int exp_cnt [3];

   function automatic int eff_phase(int l, int p);
      return (p < 0 && s_acc && l > 1) ? 0 : p;
   endfunction

   function automatic logic [6:0] exp_out(int l, bit b, int e);
      bit hit, exempt;
      if (!rst_n) return V_IDLE;
      if (e >= 0 && e <= l - 2) return V_FROZEN;
      if (s_br) return V_FLUSH;
      hit = s_mr && (s_rd != 0) && ((s_rd == s_rs1) || (s_uses2 && s_rd == s_rs2));
      exempt = b && s_mw && (s_rd == s_rs2) && (s_rd != s_rs1);
      return (hit && !exempt) ? V_STALL : V_IDLE;
   endfunction

   function automatic logic [1:0] exp_state(int l, int e);
      if (e <= 0) return 2'd0;
      if (e == l - 1) return 2'd2;
      return 2'd1;
   endfunction

   task automatic set_idle();
      s_rs1 = 0; s_rs2 = 0; s_rd = 0;
      s_uses2 = 0; s_mw = 0; s_mr = 0; s_acc = 0; s_br = 0;
   endtask

   task automatic reset_model();
      for (int i = 0; i < 3; i++) begin
         ph[i] = -1;
         exp_cnt[i] = 0;
      end
   endtask

   // Advance model by one clock edge, then move to 1 time unit past the edge.
   task automatic tick();
      for (int i = 0; i < 3; i++) begin
         int e;
         logic [6:0] v;
         e = eff_phase(lat[i], ph[i]);
         v = exp_out(lat[i], byp[i], e);
         if (v[6] == 1'b0 && exp_cnt[i] < 65535) exp_cnt[i]++;
         ph[i] = (e >= 0 && e < lat[i] - 1) ? e + 1 : -1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      set_idle();
      reset_model();
      #2;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      reset_model();
      s_acc = 1; s_br = 1; s_mr = 1; s_rd = 3; s_rs1 = 3; s_rs2 = 0;
      s_uses2 = 0; s_mw = 0;
      #1;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (o_vec[i] !== V_IDLE) begin
            failures++; $display("FAIL reset_outs dut%0d got=%b exp=%b", i, o_vec[i], V_IDLE);
         end
         checks++;
         if (o_st[i] !== 2'd0 || o_cnt[i] !== 16'd0) begin
            failures++; $display("FAIL reset_state dut%0d st=%0d cnt=%0d exp 0/0", i, o_st[i], o_cnt[i]);
         end
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (o_st[i] !== 2'd0 || o_cnt[i] !== 16'd0 || o_vec[i] !== V_IDLE) begin
            failures++; $display("FAIL reset_held dut%0d st=%0d cnt=%0d v=%b", i, o_st[i], o_cnt[i], o_vec[i]);
         end
      end
      set_idle();
      rst_n = 1'b1;
   endtask

   task automatic test_load_use();
      pulse_reset();
      s_mr = 1; s_rd = 5; s_rs1 = 5;
      #1;
      checks++;
      if (o_vec[0] !== V_STALL) begin
         failures++; $display("FAIL load_use_outs got=%b exp=%b", o_vec[0], V_STALL);
      end
      tick();
      set_idle();
      #1;
      checks++;
      if (o_cnt[0] !== 16'd1 || o_vec[0] !== V_IDLE) begin
         failures++; $display("FAIL load_use_after cnt=%0d exp=1 v=%b exp=%b", o_cnt[0], o_vec[0], V_IDLE);
      end
   endtask

   task automatic test_ldsd();
      pulse_reset();
      s_mr = 1; s_rd = 7; s_rs2 = 7; s_rs1 = 2; s_mw = 1; s_uses2 = 1;
      #1;
      checks++;
      if (o_vec[0] !== V_IDLE) begin
         failures++; $display("FAIL ldsd_bypass got=%b exp=%b", o_vec[0], V_IDLE);
      end
      checks++;
      if (o_vec[2] !== V_STALL) begin
         failures++; $display("FAIL ldsd_nobypass got=%b exp=%b", o_vec[2], V_STALL);
      end
      tick();
      set_idle();
      #1;
      checks++;
      if (o_cnt[0] !== 16'd0 || o_cnt[2] !== 16'd1) begin
         failures++; $display("FAIL ldsd_cnt a=%0d exp=0 d=%0d exp=1", o_cnt[0], o_cnt[2]);
      end
   endtask

   task automatic test_x0();
      pulse_reset();
      s_mr = 1; s_rd = 0; s_rs1 = 0; s_rs2 = 0; s_uses2 = 1;
      #1;
      checks++;
      if (o_vec[0] !== V_IDLE || o_vec[2] !== V_IDLE) begin
         failures++; $display("FAIL x0_nostall a=%b d=%b exp=%b", o_vec[0], o_vec[2], V_IDLE);
      end
      tick();
      set_idle();
      #1;
      checks++;
      if (o_cnt[0] !== 16'd0) begin
         failures++; $display("FAIL x0_cnt got=%0d exp=0", o_cnt[0]);
      end
   endtask

   task automatic test_freeze();
      logic [1:0] st_seq [8] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd0, 2'd1, 2'd1, 2'd2};
      logic       pc_seq [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      pulse_reset();
      s_acc = 1;
      for (int k = 0; k < 8; k++) begin
         #1;
         checks++;
         if (o_st[1] !== st_seq[k] || o_vec[1][6] !== pc_seq[k] || o_vec[1][0] !== ~pc_seq[k]) begin
            failures++;
            $display("FAIL freeze_seq cyc=%0d st=%0d exp=%0d pc=%b exp=%b bubble=%b",
                     k, o_st[1], st_seq[k], o_vec[1][6], pc_seq[k], o_vec[1][0]);
         end
         if (k == 0) begin
            checks++;
            if (o_vec[0] !== V_IDLE) begin
               failures++; $display("FAIL lat1_nofreeze got=%b exp=%b", o_vec[0], V_IDLE);
            end
         end
         tick();
      end
      s_acc = 0;
      #1;
      checks++;
      if (o_st[1] !== 2'd0 || o_cnt[1] !== 16'd6) begin
         failures++; $display("FAIL freeze_end st=%0d exp=0 cnt=%0d exp=6", o_st[1], o_cnt[1]);
      end
      checks++;
      if (o_st[0] !== 2'd0 || o_cnt[0] !== 16'd0) begin
         failures++; $display("FAIL lat1_state st=%0d cnt=%0d exp 0/0", o_st[0], o_cnt[0]);
      end
   endtask

   task automatic test_priority();
      pulse_reset();
      s_br = 1; s_mr = 1; s_rd = 5; s_rs1 = 5;
      #1;
      checks++;
      if (o_vec[0] !== V_FLUSH) begin
         failures++; $display("FAIL prio_flush_over_stall got=%b exp=%b", o_vec[0], V_FLUSH);
      end
      set_idle();
      s_acc = 1;
      #1;
      tick();
      s_br = 1; s_mr = 1; s_rd = 5; s_rs1 = 5;
      for (int k = 0; k < 2; k++) begin
         #1;
         checks++;
         if (o_vec[1] !== V_FROZEN || o_st[1] !== 2'd1) begin
            failures++; $display("FAIL prio_frozen cyc=%0d got=%b st=%0d exp=%b st=1", k, o_vec[1], o_st[1], V_FROZEN);
         end
         tick();
      end
      #1;
      checks++;
      if (o_vec[1] !== V_FLUSH || o_st[1] !== 2'd2) begin
         failures++; $display("FAIL prio_release_flush got=%b st=%0d exp=%b st=2", o_vec[1], o_st[1], V_FLUSH);
      end
      set_idle();
   endtask

   task automatic test_reset_mid_wait();
      pulse_reset();
      s_acc = 1;
      tick();
      tick();
      #1;
      checks++;
      if (o_st[2] !== 2'd1 || o_cnt[2] !== 16'd2) begin
         failures++; $display("FAIL midwait_pre st=%0d exp=1 cnt=%0d exp=2", o_st[2], o_cnt[2]);
      end
      #1;
      rst_n = 1'b0;
      s_br = 1;
      reset_model();
      #1;
      checks++;
      if (o_st[2] !== 2'd0 || o_cnt[2] !== 16'd0 || o_vec[2] !== V_IDLE) begin
         failures++; $display("FAIL midwait_reset st=%0d cnt=%0d v=%b exp 0/0/%b", o_st[2], o_cnt[2], o_vec[2], V_IDLE);
      end
      rst_n = 1'b1;
      #1;
      checks++;
      if (o_st[2] !== 2'd0 || o_vec[2] !== V_FROZEN) begin
         failures++; $display("FAIL midwait_fresh st=%0d v=%b exp 0/%b", o_st[2], o_vec[2], V_FROZEN);
      end
      tick();
      set_idle();
   endtask

   task automatic test_random();
      pulse_reset();
      for (int n = 0; n < 400; n++) begin
         s_rs1   = 5'($urandom_range(0, 3));
         s_rs2   = 5'($urandom_range(0, 3));
         s_rd    = 5'($urandom_range(0, 3));
         s_uses2 = 1'($urandom_range(0, 1));
         s_mw    = 1'($urandom_range(0, 1));
         s_mr    = 1'($urandom_range(0, 1));
         s_acc   = ($urandom_range(0, 3) == 0);
         s_br    = ($urandom_range(0, 4) == 0);
         #1;
         for (int i = 0; i < 3; i++) begin
            int e;
            logic [6:0] v;
            logic [1:0] st;
            e  = eff_phase(lat[i], ph[i]);
            v  = exp_out(lat[i], byp[i], e);
            st = exp_state(lat[i], e);
            checks++;
            if (o_vec[i] !== v) begin
               failures++; $display("FAIL rand_outs n=%0d dut%0d got=%b exp=%b", n, i, o_vec[i], v);
            end
            checks++;
            if (o_st[i] !== st) begin
               failures++; $display("FAIL rand_state n=%0d dut%0d got=%0d exp=%0d", n, i, o_st[i], st);
            end
            checks++;
            if (o_cnt[i] !== 16'(exp_cnt[i])) begin
               failures++; $display("FAIL rand_cnt n=%0d dut%0d got=%0d exp=%0d", n, i, o_cnt[i], exp_cnt[i]);
            end
         end
         tick();
      end
      set_idle();
   endtask

   initial begin
      set_idle();
      test_reset();
      test_load_use();
      test_ldsd();
      test_x0();
      test_freeze();
      test_priority();
      test_reset_mid_wait();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
